output_port_demux: RTL and testbench

OUTPUT_PORT_DEMUX -- requirements
Module: output_port_demux

---
 rtl/output_port_demux_pkg.sv | 19 +
 rtl/output_port_demux_fifo.sv | 63 ++++++
 rtl/output_port_demux.sv | 127 ++++++++++++
 tb/tb_output_port_demux.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_port_demux_pkg.sv
// Shared defines for the output port demultiplexer: IOQ header constants,
// destination field geometry and FSM state encoding.
package output_port_demux_pkg;

    localparam logic [7:0] IOQ_CTRL_DEF     = 8'hFF;
    localparam int         DST_PORT_POS_DEF = 0;
    localparam int         DST_FIELD_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } demux_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/output_port_demux_fifo.sv
// small_fifo: first-word-fall-through FIFO; dout always shows the head word
// while empty is low.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);
    localparam int                      DEPTH   = 2 ** MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_L = (MAX_DEPTH_BITS + 1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NF_L    = (MAX_DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_depth;
    logic                      w_full;
    logic                      w_do_wr;
    logic                      w_do_rd;

    assign w_full      = (r_depth == DEPTH_L);
    assign empty       = (r_depth == {(MAX_DEPTH_BITS + 1){1'b0}});
    assign nearly_full = (r_depth >= NF_L);
    assign dout        = r_mem[r_rd_ptr];
    assign w_do_wr     = wr_en && !w_full;
    assign w_do_rd     = rd_en && !empty;

    // storage array, no reset needed since depth gates visibility
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // pointers and occupancy; simultaneous read+write leaves depth unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {MAX_DEPTH_BITS{1'b0}};
            r_rd_ptr <= {MAX_DEPTH_BITS{1'b0}};
            r_depth  <= {(MAX_DEPTH_BITS + 1){1'b0}};
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_depth <= r_depth + 1'b1;
                2'b01:   r_depth <= r_depth - 1'b1;
                default: r_depth <= r_depth;
            endcase
        end
    end

endmodule

// File: rtl/output_port_demux.sv
// Routes packets from one input stream to a one-hot/multicast set of output
// ports chosen by the IOQ header; packets without a usable header are dropped.
module output_port_demux
    import output_port_demux_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int                    NUM_PORTS    = 4,
    parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL     = CTRL_WIDTH'(IOQ_CTRL_DEF),
    parameter int                    DST_PORT_POS = DST_PORT_POS_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
    output logic [NUM_PORTS*CTRL_WIDTH-1:0]  out_ctrl,
    output logic [NUM_PORTS-1:0]             out_wr,
    input  logic [NUM_PORTS-1:0]             out_rdy,
    output logic [15:0]                      drop_count
);
    localparam int FW = DATA_WIDTH + CTRL_WIDTH;

    logic [FW-1:0]         w_fifo_dout;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CTRL_WIDTH-1:0] w_head_ctrl;
    logic                  w_empty;
    logic                  w_nearly_full;
    logic                  w_pop;
    logic                  w_is_eop;
    logic                  w_all_rdy;
    logic                  w_hdr_ok;
    logic [NUM_PORTS-1:0]  w_head_mask;

    demux_state_e          r_state;
    logic [NUM_PORTS-1:0]  r_mask;
    logic                  r_prev_ctrl_zero;

    small_fifo #(
        .WIDTH          (FW),
        .MAX_DEPTH_BITS (2)
    ) u_in_fifo (
        .din         ({in_ctrl, in_data}),
        .wr_en       (in_wr),
        .rd_en       (w_pop),
        .dout        (w_fifo_dout),
        .nearly_full (w_nearly_full),
        .empty       (w_empty),
        .reset       (reset),
        .clk         (clk)
    );

    assign in_rdy      = !w_nearly_full;
    assign w_head_data = w_fifo_dout[DATA_WIDTH-1:0];
    assign w_head_ctrl = w_fifo_dout[FW-1:DATA_WIDTH];
    // EOP is only recognised after at least one data word of the packet
    assign w_is_eop    = r_prev_ctrl_zero && (w_head_ctrl != {CTRL_WIDTH{1'b0}});
    assign w_all_rdy   = &(out_rdy | ~r_mask);
    assign w_hdr_ok    = (w_head_ctrl == IOQ_CTRL) && (w_head_mask != {NUM_PORTS{1'b0}});

    // even bits of the destination field select MAC ports
    always_comb begin
        w_head_mask = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (2 * i < DST_FIELD_W) begin
                w_head_mask[i] = w_head_data[DST_PORT_POS + 2 * i];
            end else begin
                w_head_mask[i] = 1'b0;
            end
        end
    end

    // pop qualification per FSM state
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            ST_FWD:  w_pop = !w_empty && w_all_rdy;
            ST_DROP: w_pop = !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    // FSM, mask latch, EOP tracking, registered outputs and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_mask           <= {NUM_PORTS{1'b0}};
            r_prev_ctrl_zero <= 1'b0;
            out_wr           <= {NUM_PORTS{1'b0}};
            out_data         <= {(NUM_PORTS * DATA_WIDTH){1'b0}};
            out_ctrl         <= {(NUM_PORTS * CTRL_WIDTH){1'b0}};
            drop_count       <= 16'd0;
        end else begin
            out_wr <= {NUM_PORTS{1'b0}};
            if (w_pop) begin
                r_prev_ctrl_zero <= (w_head_ctrl == {CTRL_WIDTH{1'b0}});
                out_data         <= {NUM_PORTS{w_head_data}};
                out_ctrl         <= {NUM_PORTS{w_head_ctrl}};
                if (r_state == ST_FWD) begin
                    out_wr <= r_mask;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (w_hdr_ok) begin
                            r_mask  <= w_head_mask;
                            r_state <= ST_FWD;
                        end else begin
                            r_state    <= ST_DROP;
                            drop_count <= sat_inc16(drop_count);
                        end
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (w_pop && w_is_eop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_demux.sv
// Scoreboard bench for output_port_demux: packets are classified by a
// packet-level reference model and expected words queued per output port.
module tb_output_port_demux;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NP = 4;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } word_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [DW-1:0]    in_data;
    logic [CW-1:0]    in_ctrl;
    logic             in_wr;
    logic             in_rdy;
    logic [NP*DW-1:0] out_data;
    logic [NP*CW-1:0] out_ctrl;
    logic [NP-1:0]    out_wr;
    logic [NP-1:0]    out_rdy;
    logic [15:0]      drop_count;

    output_port_demux dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    int        exp_drops = 0;
    word_t     exp_q [NP][$];
    word_t     pkt_q [$];
    word_t     full_q [$];
    logic      rdy_random = 1'b0;
    logic [NP-1:0] rdy_force = '1;
    logic      mc_chk = 1'b0;
    logic      rec_first = 1'b0;
    int        t_first = 0;
    int        p0_first = -1;
    int        p0_last = 0;
    int        p0_cnt = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        out_rdy = rdy_random ? NP'($urandom) : rdy_force;
    end

    // monitor: pops expected words whenever a port is written
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0) begin
            if (mc_chk && (out_wr[0] || out_wr[2]))
                check("mcast_sync", 256'(out_wr[0]), 256'(out_wr[2]));
            for (int p = 0; p < NP; p++) begin
                if (out_wr[p] === 1'b1) begin
                    if (p == 0) begin
                        if (p0_first < 0) p0_first = cyc;
                        p0_last = cyc;
                        p0_cnt++;
                    end
                    if (exp_q[p].size() == 0) begin
                        check($sformatf("unexpected_wr_port%0d", p), 256'(1), 256'(0));
                    end else begin
                        word_t e;
                        word_t g;
                        e = exp_q[p].pop_front();
                        g = {out_ctrl[p*CW +: CW], out_data[p*DW +: DW]};
                        check($sformatf("port%0d_word", p), 256'(g), 256'(e));
                    end
                end
            end
        end
    end

    // reference model: forward whole packet to every selected port, or count a drop
    task automatic model_pkt();
        word_t h;
        logic [NP-1:0] m;
        h = pkt_q[0];
        for (int p = 0; p < NP; p++) m[p] = ((h.data >> (2 * p)) & 64'd1) != 64'd0;
        if (h.ctrl == 8'hFF && m != '0) begin
            for (int p = 0; p < NP; p++)
                if (m[p]) foreach (pkt_q[j]) exp_q[p].push_back(pkt_q[j]);
        end else begin
            exp_drops++;
        end
    endtask

    task automatic drive_word(input word_t w);
        int waited = 0;
        while (!in_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_rdy) begin
            check("in_rdy_timeout", 256'(0), 256'(1));
        end else begin
            if (rec_first) begin
                t_first = cyc;
                rec_first = 1'b0;
            end
            in_data = w.data;
            in_ctrl = w.ctrl;
            in_wr = 1'b1;
            @(negedge clk);
            in_wr = 1'b0;
        end
    endtask

    task automatic send_cur();
        model_pkt();
        foreach (pkt_q[j]) drive_word(pkt_q[j]);
    endtask

    task automatic build_pkt(input logic [CW-1:0] c0, input logic [DW-1:0] d0,
                             input logic [CW-1:0] hctrl, input int nhdr,
                             input int ndata, input logic [CW-1:0] ectrl);
        pkt_q.delete();
        pkt_q.push_back({c0, d0});
        for (int j = 0; j < nhdr; j++) pkt_q.push_back({hctrl, {$urandom, $urandom}});
        for (int j = 0; j < ndata; j++) pkt_q.push_back({8'h00, {$urandom, $urandom}});
        pkt_q.push_back({ectrl, {$urandom, $urandom}});
    endtask

    function automatic logic [DW-1:0] hdr_data(input logic [NP-1:0] m);
        logic [DW-1:0] d;
        d = {$urandom, $urandom} & ~64'h55;
        for (int p = 0; p < NP; p++) d = d | (64'(m[p]) << (2 * p));
        return d;
    endfunction

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 256'(0), 256'(1));
        repeat (8) @(negedge clk);
    endtask

    initial begin
        in_wr = 1'b0;
        in_data = '0;
        in_ctrl = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_out_wr", 256'(out_wr), 256'(0));
        check("rst_drop_count", 256'(drop_count), 256'(0));
        check("rst_in_rdy", 256'(in_rdy), 256'(1));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_out_ctrl", 256'(out_ctrl), 256'(0));

        // unicast to port 0, back-to-back with one-cycle pop latency
        build_pkt(8'hFF, hdr_data(4'b0001), 8'h04, 1, 3, 8'h01);
        p0_first = -1;
        p0_cnt = 0;
        rec_first = 1'b1;
        send_cur();
        wait_drain(200);
        check("p0_word_count", 256'(p0_cnt), 256'(6));
        check("p0_back_to_back", 256'(p0_last - p0_first), 256'(5));
        check("p0_first_latency", 256'(p0_first - t_first), 256'(3));

        // multicast to ports 0 and 2 with port 2 stalled mid-packet
        mc_chk = 1'b1;
        build_pkt(8'hFF, hdr_data(4'b0101), 8'h04, 1, 3, 8'h01);
        fork
            send_cur();
            begin
                repeat (4) @(negedge clk);
                rdy_force[2] = 1'b0;
                repeat (5) @(negedge clk);
                rdy_force[2] = 1'b1;
            end
        join
        wait_drain(200);
        mc_chk = 1'b0;

        // empty destination mask, then a good packet
        build_pkt(8'hFF, hdr_data(4'b0000), 8'h04, 1, 2, 8'h01);
        send_cur();
        build_pkt(8'hFF, hdr_data(4'b1000), 8'h04, 0, 2, 8'h02);
        send_cur();
        wait_drain(200);
        check("drop_after_mask0", 256'(drop_count), 256'(exp_drops));

        // headerless packet, then a good packet
        build_pkt(8'h04, {$urandom, $urandom}, 8'h04, 1, 3, 8'h01);
        send_cur();
        build_pkt(8'hFF, hdr_data(4'b0110), 8'h04, 1, 1, 8'h01);
        send_cur();
        wait_drain(200);
        check("drop_after_noioq", 256'(drop_count), 256'(exp_drops));

        // reset after two data words of a port-1 packet
        build_pkt(8'hFF, hdr_data(4'b0010), 8'h04, 1, 3, 8'h01);
        full_q = pkt_q;
        for (int j = 0; j < 4; j++) begin
            exp_q[1].push_back(full_q[j]);
            drive_word(full_q[j]);
        end
        wait_drain(100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_drops = 0;
        check("midpkt_rst_out_wr", 256'(out_wr), 256'(0));
        check("midpkt_rst_drop_count", 256'(drop_count), 256'(0));
        pkt_q.delete();
        for (int j = 4; j < 6; j++) pkt_q.push_back(full_q[j]);
        send_cur();
        build_pkt(8'hFF, hdr_data(4'b0010), 8'h04, 0, 2, 8'h01);
        send_cur();
        wait_drain(200);
        check("drop_after_reset", 256'(drop_count), 256'(exp_drops));

        // random traffic with out_rdy toggling
        rdy_random = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int kind = $urandom_range(0, 9);
            int nh = $urandom_range(0, 2);
            int nd = $urandom_range(1, 4);
            logic [CW-1:0] ec = 8'($urandom_range(1, 255));
            if (kind == 0)
                build_pkt(8'($urandom_range(1, 254)), {$urandom, $urandom}, 8'h04, nh, nd, ec);
            else if (kind == 1)
                build_pkt(8'hFF, hdr_data(4'b0000), 8'h08, nh, nd, ec);
            else
                build_pkt(8'hFF, hdr_data(4'($urandom_range(1, 15))), 8'h10, nh, nd, ec);
            send_cur();
        end
        rdy_random = 1'b0;
        rdy_force = '1;
        wait_drain(5000);
        check("final_drop_count", 256'(drop_count), 256'(exp_drops));
        for (int p = 0; p < NP; p++)
            check($sformatf("final_queue_empty_port%0d", p), 256'(exp_q[p].size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
